// File: rtl/rob_complete_arbiter_if.sv
// Completion bus between the execution units and the ROB completion arbiter.
// The master side is the execute stage; the slave side is the arbiter that drives the ROB write port.
interface rob_complete_arbiter_if #(
  parameter int NUM_REQ       = 4,
  parameter int ROB_ADDRWIDTH = 6
);
  logic [NUM_REQ-1:0]               tARB_req_IN;
  logic [NUM_REQ*ROB_ADDRWIDTH-1:0] tARB_robIdx_IN;
  logic [NUM_REQ-1:0]               tARB_exp_IN;
  logic [NUM_REQ-1:0]               tARB_taken_IN;
  logic [NUM_REQ*32-1:0]            tARB_targetPC_IN;
  logic [NUM_REQ-1:0]               fARB_grant_OUT;
  logic [ROB_ADDRWIDTH-1:0]         fARB_probeIdx_OUT;
  logic                             fARB_setFin_OUT;
  logic                             fARB_setExp_OUT;
  logic                             fARB_taken_OUT;
  logic [31:0]                      fARB_targetPC_OUT;
  logic                             fARB_pending_OUT;

  modport master (
    output tARB_req_IN, tARB_robIdx_IN, tARB_exp_IN, tARB_taken_IN, tARB_targetPC_IN,
    input  fARB_grant_OUT, fARB_probeIdx_OUT, fARB_setFin_OUT, fARB_setExp_OUT,
           fARB_taken_OUT, fARB_targetPC_OUT, fARB_pending_OUT
  );

  modport slave (
    input  tARB_req_IN, tARB_robIdx_IN, tARB_exp_IN, tARB_taken_IN, tARB_targetPC_IN,
    output fARB_grant_OUT, fARB_probeIdx_OUT, fARB_setFin_OUT, fARB_setExp_OUT,
           fARB_taken_OUT, fARB_targetPC_OUT, fARB_pending_OUT
  );
endinterface

// File: rtl/rob_complete_arbiter.sv
// Round-robin arbiter sharing the single ROB completion write port among NUM_REQ execution units.
// Grant is combinational; the winning completion is written to the ROB one cycle later from registers.
module rob_complete_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int ROB_ADDRWIDTH = 6,
  parameter int PTR_WIDTH     = 2
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 FREEZE,
  input  logic                 FLUSH_IN,
  rob_complete_arbiter_if.slave arbIf
);

  logic [PTR_WIDTH-1:0]     rrPtr_r;
  logic [ROB_ADDRWIDTH-1:0] probeIdx_r;
  logic                     setFin_r;
  logic                     setExp_r;
  logic                     taken_r;
  logic [31:0]              targetPC_r;

  logic                     arbActive_s;
  logic [NUM_REQ-1:0]       reqEff_s;
  logic [NUM_REQ-1:0]       grant_s;
  logic                     winValid_s;
  int                       winIdx_s;
  int                       basePtr_s;
  logic [PTR_WIDTH-1:0]     nextPtr_s;
  logic [ROB_ADDRWIDTH-1:0] selIdx_s;
  logic                     selExp_s;
  logic                     selTaken_s;
  logic [31:0]              selPC_s;

  assign arbActive_s = !RESET && !FREEZE && !FLUSH_IN;
  assign reqEff_s    = arbActive_s ? arbIf.tARB_req_IN : {NUM_REQ{1'b0}};

  // Round-robin winner search: first pass from the pointer upward, second pass wraps from unit 0.
  always_comb begin
    logic hit;
    winValid_s = 1'b0;
    winIdx_s   = 0;
    // An out-of-range pointer (non-power-of-2 NUM_REQ) restarts the scan at unit 0.
    basePtr_s  = (int'(rrPtr_r) >= NUM_REQ) ? 0 : int'(rrPtr_r);
    for (int k = 0; k < NUM_REQ; k++) begin
      hit        = !winValid_s && reqEff_s[k] && (k >= basePtr_s);
      winIdx_s   = hit ? k : winIdx_s;
      winValid_s = winValid_s | hit;
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      hit        = !winValid_s && reqEff_s[k];
      winIdx_s   = hit ? k : winIdx_s;
      winValid_s = winValid_s | hit;
    end
  end

  // One-hot grant and payload selection for the winner.
  always_comb begin
    grant_s    = {NUM_REQ{1'b0}};
    selIdx_s   = {ROB_ADDRWIDTH{1'b0}};
    selExp_s   = 1'b0;
    selTaken_s = 1'b0;
    selPC_s    = 32'h0;
    for (int k = 0; k < NUM_REQ; k++) begin
      grant_s[k] = winValid_s && (winIdx_s == k);
      selIdx_s   = grant_s[k] ? arbIf.tARB_robIdx_IN[k*ROB_ADDRWIDTH +: ROB_ADDRWIDTH] : selIdx_s;
      selExp_s   = grant_s[k] ? arbIf.tARB_exp_IN[k] : selExp_s;
      selTaken_s = grant_s[k] ? arbIf.tARB_taken_IN[k] : selTaken_s;
      selPC_s    = grant_s[k] ? arbIf.tARB_targetPC_IN[k*32 +: 32] : selPC_s;
    end
    nextPtr_s = (winIdx_s == NUM_REQ - 1) ? {PTR_WIDTH{1'b0}} : PTR_WIDTH'(winIdx_s + 1);
  end

  // Output write-port registers and round-robin pointer; flush wins over freeze, reset over both.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rrPtr_r    <= {PTR_WIDTH{1'b0}};
      probeIdx_r <= {ROB_ADDRWIDTH{1'b0}};
      setFin_r   <= 1'b0;
      setExp_r   <= 1'b0;
      taken_r    <= 1'b0;
      targetPC_r <= 32'h0;
    end else if (FLUSH_IN) begin
      setFin_r   <= 1'b0;
      setExp_r   <= 1'b0;
      taken_r    <= 1'b0;
    end else if (FREEZE) begin
      setFin_r   <= 1'b0;
    end else if (winValid_s) begin
      rrPtr_r    <= nextPtr_s;
      probeIdx_r <= selIdx_s;
      setFin_r   <= 1'b1;
      setExp_r   <= selExp_s;
      taken_r    <= selTaken_s;
      targetPC_r <= selTaken_s ? selPC_s : 32'h0;
    end else begin
      setFin_r   <= 1'b0;
    end
  end

  assign arbIf.fARB_grant_OUT    = grant_s;
  assign arbIf.fARB_pending_OUT  = |(arbIf.tARB_req_IN & ~grant_s);
  assign arbIf.fARB_probeIdx_OUT = probeIdx_r;
  assign arbIf.fARB_setFin_OUT   = setFin_r;
  assign arbIf.fARB_setExp_OUT   = setExp_r;
  assign arbIf.fARB_taken_OUT    = taken_r;
  assign arbIf.fARB_targetPC_OUT = targetPC_r;

endmodule

// File: tb/tb_rob_complete_arbiter.sv
// Randomized bench for rob_complete_arbiter against a behavioural round-robin model.
// Directed scenarios first, then random requests with random freeze/flush/reset.
module tb_rob_complete_arbiter;
  localparam int NUM_REQ = 4;
  localparam int W       = 6;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic FREEZE = 1'b0;
  logic FLUSH_IN = 1'b0;

  always #5 CLK = ~CLK;

  rob_complete_arbiter_if #(.NUM_REQ(NUM_REQ), .ROB_ADDRWIDTH(W)) arbIf ();

  rob_complete_arbiter #(.NUM_REQ(NUM_REQ), .ROB_ADDRWIDTH(W), .PTR_WIDTH(2)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .FREEZE   (FREEZE),
    .FLUSH_IN (FLUSH_IN),
    .arbIf    (arbIf)
  );

  int errCnt = 0;
  int chkCnt = 0;

  // Per-unit pending completion, as the execution units see it.
  bit          uReq[NUM_REQ];
  logic [W-1:0] uIdx[NUM_REQ];
  bit          uExp[NUM_REQ];
  bit          uTaken[NUM_REQ];
  logic [31:0] uPc[NUM_REQ];

  // Reference state of the ROB write port.
  int          rrM = 0;
  bit          finM = 0, expM = 0, takenM = 0;
  logic [W-1:0] idxM = '0;
  logic [31:0] pcM = '0;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    chkCnt++;
    if (obs !== expv) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic int modelWinner(input bit rst, input bit frz, input bit fl);
    if (rst || frz || fl) return -1;
    for (int i = 0; i < NUM_REQ; i++) begin
      int u = (rrM + i) % NUM_REQ;
      if (uReq[u]) return u;
    end
    return -1;
  endfunction

  task automatic driveBus();
    for (int k = 0; k < NUM_REQ; k++) begin
      arbIf.tARB_req_IN[k]                = uReq[k];
      arbIf.tARB_robIdx_IN[k*W +: W]      = uIdx[k];
      arbIf.tARB_exp_IN[k]                = uExp[k];
      arbIf.tARB_taken_IN[k]              = uTaken[k];
      arbIf.tARB_targetPC_IN[k*32 +: 32]  = uPc[k];
    end
  endtask

  task automatic setUnit(input int k, input logic [W-1:0] idx, input bit e, input bit t, input logic [31:0] pc);
    uReq[k] = 1'b1; uIdx[k] = idx; uExp[k] = e; uTaken[k] = t; uPc[k] = pc;
  endtask

  task automatic cycle(input bit rst, input bit frz, input bit fl);
    int w;
    logic [NUM_REQ-1:0] reqVec, expGrant;
    RESET = rst; FREEZE = frz; FLUSH_IN = fl;
    driveBus();
    @(negedge CLK);
    w = modelWinner(rst, frz, fl);
    expGrant = '0;
    if (w >= 0) expGrant[w] = 1'b1;
    for (int k = 0; k < NUM_REQ; k++) reqVec[k] = uReq[k];
    checkVal("grant", 64'(arbIf.fARB_grant_OUT), 64'(expGrant));
    checkVal("pending", 64'(arbIf.fARB_pending_OUT), 64'(|(reqVec & ~expGrant)));
    @(posedge CLK);
    if (rst) begin
      rrM = 0; finM = 0; expM = 0; takenM = 0; idxM = '0; pcM = '0;
    end else if (fl) begin
      finM = 0; expM = 0; takenM = 0;
    end else if (frz) begin
      finM = 0;
    end else if (w >= 0) begin
      finM = 1; idxM = uIdx[w]; expM = uExp[w]; takenM = uTaken[w];
      pcM = uTaken[w] ? uPc[w] : 32'h0;
      rrM = (w + 1) % NUM_REQ;
    end else begin
      finM = 0;
    end
    if (w >= 0) uReq[w] = 1'b0;
    if (fl || rst) for (int k = 0; k < NUM_REQ; k++) uReq[k] = 1'b0;
    #1;
    checkVal("setFin", 64'(arbIf.fARB_setFin_OUT), 64'(finM));
    checkVal("setExp", 64'(arbIf.fARB_setExp_OUT), 64'(expM));
    checkVal("taken", 64'(arbIf.fARB_taken_OUT), 64'(takenM));
    checkVal("probeIdx", 64'(arbIf.fARB_probeIdx_OUT), 64'(idxM));
    checkVal("targetPC", 64'(arbIf.fARB_targetPC_OUT), 64'(pcM));
  endtask

  initial begin
    for (int k = 0; k < NUM_REQ; k++) begin
      uReq[k] = 0; uIdx[k] = '0; uExp[k] = 0; uTaken[k] = 0; uPc[k] = '0;
    end
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);

    // Single requester on unit 2.
    setUnit(2, 6'd17, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0);
    checkVal("t1_probeIdx", 64'(arbIf.fARB_probeIdx_OUT), 64'd17);
    checkVal("t1_setFin", 64'(arbIf.fARB_setFin_OUT), 64'd1);

    // All units requesting continuously from pointer 0.
    cycle(1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 6; n++) begin
      for (int k = 0; k < NUM_REQ; k++)
        if (!uReq[k]) setUnit(k, 6'(k * 8 + n), 1'b0, 1'b0, 32'h0);
      cycle(1'b0, 1'b0, 1'b0);
    end
    for (int k = 0; k < NUM_REQ; k++) uReq[k] = 0;

    // Taken branch on unit 3, then a plain completion on unit 0.
    cycle(1'b1, 1'b0, 1'b0);
    setUnit(3, 6'd5, 1'b0, 1'b1, 32'h0040_0100);
    cycle(1'b0, 1'b0, 1'b0);
    checkVal("t3_target", 64'(arbIf.fARB_targetPC_OUT), 64'h0040_0100);
    setUnit(0, 6'd9, 1'b0, 1'b0, 32'hdead_beef);
    cycle(1'b0, 1'b0, 1'b0);
    checkVal("t3_target_clr", 64'(arbIf.fARB_targetPC_OUT), 64'h0);

    // Freeze with units 1 and 2 pending, then release.
    setUnit(1, 6'd33, 1'b0, 1'b0, 32'h0);
    setUnit(2, 6'd34, 1'b1, 1'b0, 32'h0);
    for (int n = 0; n < 3; n++) cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    checkVal("t4_first_after_freeze", 64'(arbIf.fARB_probeIdx_OUT), 64'd33);
    cycle(1'b0, 1'b0, 1'b0);

    // Flush with exception completions on units 0 and 3.
    setUnit(0, 6'd40, 1'b1, 1'b0, 32'h0);
    setUnit(3, 6'd41, 1'b1, 1'b1, 32'h1000);
    cycle(1'b0, 1'b0, 1'b1);
    checkVal("t5_setExp", 64'(arbIf.fARB_setExp_OUT), 64'd0);

    // Reset right after a grant to unit 1 discards the pending write.
    setUnit(1, 6'd50, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    checkVal("t6_setFin", 64'(arbIf.fARB_setFin_OUT), 64'd0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < NUM_REQ; k++)
        if (!uReq[k] && ($urandom % 3 == 0))
          setUnit(k, 6'($urandom), 1'($urandom), 1'($urandom), $urandom);
      cycle(($urandom % 60) == 0, ($urandom % 8) == 0, ($urandom % 20) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end
endmodule
